shift_seq_ctrl: RTL
===================

# shift_seq_ctrl

Multicycle sequencer for the CPU shift datapath. On a one-cycle `start`, it latches the shift instruction's operands and drives the 4:1 shift-amount select. It then loads and shifts the internal shift register and pulses `done` with the result. It serves SLL/SRL/SRA/SLLV/SRAV/LUI and a memory-sourced right shift for the main control unit, so the main FSM issues one request instead of stepping the shift register itself.

## Interface
- `DATA_W`, 32, data width of the shift register.
- `SHAMT_W`, 5, shift-amount width; must equal log2(`DATA_W`).

Ports:
- `clk`  in  1  system clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-low reset (sampled on `clk`; `reset`==0 resets).
- `start`  in  1  request strobe; honoured only in IDLE.
- `op`  in  3  shift operation code (see Operation).
- `src_data`  in  DATA_W  value to be shifted.
- `shamt_field`  in  SHAMT_W  instruction shamt field (select 0).
- `rs_val`  in  DATA_W  register operand; bits [4:0] are select 1.
- `mem_val`  in  DATA_W  memory data; bits [4:0] are select 3.
- `busy`  out  1  high from the cycle after an accepted `start` until `done` inclusive.
- `done`  out  1  one-cycle pulse; `result` valid that cycle and held until the next accepted `start`.
- `err`  out  1  valid with `done`; 1 = illegal `op`.
- `result`  out  DATA_W  shift register output.
- `shamt_sel`  out  2  current shift-amount select (0 field, 1 rs, 2 constant 16, 3 mem).
- `shift_op`  out  3  command to the shift register: 000 hold, 001 load, 010 left logical, 011 right logical, 100 right arithmetic.

## Operation
- `op` encoding, as amount source / shift_op:
  - 000 SLL: field / 010
  - 001 SRL: field / 011
  - 010 SRA: field / 100
  - 011 SLLV: rs / 010
  - 100 SRAV: rs / 100
  - 101 LUI: const 16 / 010
  - 110 SRLM: mem / 011
  - 111 illegal
- On an accepted `start`, latch `op`, `src_data`, `shamt_field`, `rs_val[4:0]` and `mem_val[4:0]`. Later input changes have no effect on the request in progress.
- The shift amount is the mux output, which is purely combinational on `shamt_sel` and the latched sources. Constant source = 5'b10000.
- FSM states: IDLE, LOAD, SHIFT, DONE.
  - IDLE → LOAD on `start`.
  - LOAD: `shift_op`=001 and the register captures latched `src_data`. Next state is SHIFT, or DONE for an illegal `op`.
  - SHIFT: `shift_op` per op and the register shifts by the amount in one cycle. → DONE.
  - DONE: `done`=1 and `shift_op`=000. → IDLE unconditionally.
- Shift by 0 gives `result` = `src_data`.
- Right arithmetic replicates bit DATA_W-1. Logical shifts fill with 0.
- Illegal `op`: `result` = `src_data` (loaded, not shifted) and `err`=1.
- `start` while not IDLE is ignored, with no queueing. `start` in the DONE cycle is also ignored.
- `shamt_sel` holds its last value in IDLE. It is set from `op` in LOAD and is stable through SHIFT.

## Timing
- Reset values: `busy`=0, `done`=0, `err`=0, `result`=0, `shamt_sel`=00, `shift_op`=000, state IDLE, latched operands 0.
- Latency: `start` sampled at edge N. LOAD is cycle N+1, SHIFT is N+2, and `done` is high in cycle N+3.
  - Illegal `op`: `done` is high in cycle N+2.
- Throughput: one request per 4 cycles. The next `start` is honoured in cycle N+4, first IDLE.
- Reset asserted in any state: next edge forces IDLE and all reset values, including `result`=0. The aborted request produces no `done`.
- `err` is 0 whenever `done` is 0.

## Structure
- Package `shift_pkg`:
  - `op` codes
  - `shift_op` command codes
  - `shamt_sel` codes
  - FSM state enum
  - constant `LUI_SHAMT` = 16
- Sub-module `shift_reg`: a DATA_W register with a `shift_op` command port and an amount input, performing hold/load/left/right-logical/right-arithmetic per cycle. It uses the same `clk` and active-low synchronous `reset`.
- The shift-amount mux stays inside `shift_seq_ctrl` as combinational logic.

## Test plan
- SLL: `src_data`=0x00000001, `shamt_field`=4, `start` → `done` at N+3, `result`=0x00000010, `shamt_sel`=0, `err`=0.
- SRA: `src_data`=0x80000000, `shamt_field`=31 → `result`=0xFFFFFFFF. Repeat as SRL → 0x00000001.
- LUI: `src_data`=0x00001234, `op`=101 → `shamt_sel`=2, `result`=0x12340000.
- SRAV: `rs_val`=0x00000025 (amount 5), `src_data`=0xF0000000. Change `rs_val` at N+1 → `result`=0xFF800000, proving operands were latched at `start`.
- `start` held high continuously for 8 cycles → exactly two `done` pulses, at N+3 and N+7. `op`=111 → `done` at N+2 with `err`=1 and `result`=`src_data`.
- `reset`=0 during SHIFT → no `done`, next cycle `result`=0 and `busy`=0. A following `start` completes normally.

Source files
------------

// File: rtl/shift_pkg.sv
`default_nettype none
// ============================================================================
// Module   : shift_pkg
// Purpose  : Shared codes, FSM states and op decoding for the shift sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package shift_pkg;

    typedef enum logic [2:0] {
        OP_SLL     = 3'b000,
        OP_SRL     = 3'b001,
        OP_SRA     = 3'b010,
        OP_SLLV    = 3'b011,
        OP_SRAV    = 3'b100,
        OP_LUI     = 3'b101,
        OP_SRLM    = 3'b110,
        OP_ILLEGAL = 3'b111
    } op_e;

    typedef enum logic [2:0] {
        CMD_HOLD = 3'b000,
        CMD_LOAD = 3'b001,
        CMD_SLL  = 3'b010,
        CMD_SRL  = 3'b011,
        CMD_SRA  = 3'b100
    } shift_cmd_e;

    typedef enum logic [1:0] {
        SEL_FIELD = 2'b00,
        SEL_RS    = 2'b01,
        SEL_CONST = 2'b10,
        SEL_MEM   = 2'b11
    } shamt_sel_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_LOAD  = 2'b01,
        ST_SHIFT = 2'b10,
        ST_DONE  = 2'b11
    } state_e;

    localparam int LUI_SHAMT = 16;

    typedef struct packed {
        shamt_sel_e sel;
        shift_cmd_e cmd;
        logic       illegal;
    } op_dec_t;

    function automatic op_dec_t decode_op(input logic [2:0] i_code);
        op_dec_t w_d;
        w_d = '{sel: SEL_FIELD, cmd: CMD_HOLD, illegal: 1'b0};
        case (op_e'(i_code))
            OP_SLL:  w_d = '{sel: SEL_FIELD, cmd: CMD_SLL, illegal: 1'b0};
            OP_SRL:  w_d = '{sel: SEL_FIELD, cmd: CMD_SRL, illegal: 1'b0};
            OP_SRA:  w_d = '{sel: SEL_FIELD, cmd: CMD_SRA, illegal: 1'b0};
            OP_SLLV: w_d = '{sel: SEL_RS,    cmd: CMD_SLL, illegal: 1'b0};
            OP_SRAV: w_d = '{sel: SEL_RS,    cmd: CMD_SRA, illegal: 1'b0};
            OP_LUI:  w_d = '{sel: SEL_CONST, cmd: CMD_SLL, illegal: 1'b0};
            OP_SRLM: w_d = '{sel: SEL_MEM,   cmd: CMD_SRL, illegal: 1'b0};
            default: w_d = '{sel: SEL_FIELD, cmd: CMD_HOLD, illegal: 1'b1};
        endcase
        return w_d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/shift_reg.sv
`default_nettype none
// ============================================================================
// Module   : shift_reg
// Purpose  : DATA_W register with hold/load/SLL/SRL/SRA command per cycle.
// Revision : 1.0 - initial release
// ============================================================================
module shift_reg
    import shift_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [2:0]         i_cmd,
    input  logic [DATA_W-1:0]  i_data,
    input  logic [SHAMT_W-1:0] i_amt,
    output logic [DATA_W-1:0]  o_q
);

    logic [DATA_W-1:0] r_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_q <= '0;
        end else begin
            case (shift_cmd_e'(i_cmd))
                CMD_LOAD: r_q <= i_data;
                CMD_SLL:  r_q <= r_q << i_amt;
                CMD_SRL:  r_q <= r_q >> i_amt;
                CMD_SRA:  r_q <= $signed(r_q) >>> i_amt;
                default:  r_q <= r_q;
            endcase
        end
    end

    assign o_q = r_q;

endmodule
`default_nettype wire

// File: rtl/shift_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : shift_seq_ctrl
// Purpose  : Sequences one shift request: latch operands, load, shift, done.
// Revision : 1.0 - initial release
// ============================================================================
module shift_seq_ctrl
    import shift_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [2:0]         op,
    input  logic [DATA_W-1:0]  src_data,
    input  logic [SHAMT_W-1:0] shamt_field,
    input  logic [DATA_W-1:0]  rs_val,
    input  logic [DATA_W-1:0]  mem_val,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [DATA_W-1:0]  result,
    output logic [1:0]         shamt_sel,
    output logic [2:0]         shift_op
);

    state_e             r_state;
    state_e             w_next_state;
    op_dec_t            r_dec;
    logic [DATA_W-1:0]  r_src;
    logic [SHAMT_W-1:0] r_field;
    logic [SHAMT_W-1:0] r_rs_amt;
    logic [SHAMT_W-1:0] r_mem_amt;
    logic [SHAMT_W-1:0] w_amt;
    shift_cmd_e         w_cmd;
    logic               w_accept;
    logic               w_unused;

    assign w_accept = (r_state == ST_IDLE) && start;

    // Only the low amount bits of rs/mem ever matter.
    assign w_unused = ^{rs_val[DATA_W-1:SHAMT_W], mem_val[DATA_W-1:SHAMT_W]};

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_dec     <= '0;
            r_src     <= '0;
            r_field   <= '0;
            r_rs_amt  <= '0;
            r_mem_amt <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_accept) begin
                r_dec     <= decode_op(op);
                r_src     <= src_data;
                r_field   <= shamt_field;
                r_rs_amt  <= rs_val[SHAMT_W-1:0];
                r_mem_amt <= mem_val[SHAMT_W-1:0];
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_cmd        = CMD_HOLD;
        case (r_state)
            ST_IDLE: begin
                if (start) w_next_state = ST_LOAD;
            end
            ST_LOAD: begin
                w_cmd        = CMD_LOAD;
                w_next_state = r_dec.illegal ? ST_DONE : ST_SHIFT;
            end
            ST_SHIFT: begin
                w_cmd        = r_dec.cmd;
                w_next_state = ST_DONE;
            end
            ST_DONE: begin
                w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        w_amt = r_field;
        case (r_dec.sel)
            SEL_FIELD: w_amt = r_field;
            SEL_RS:    w_amt = r_rs_amt;
            SEL_CONST: w_amt = SHAMT_W'(LUI_SHAMT);
            SEL_MEM:   w_amt = r_mem_amt;
            default:   w_amt = r_field;
        endcase
    end

    shift_reg #(
        .DATA_W  (DATA_W),
        .SHAMT_W (SHAMT_W)
    ) u_shift_reg (
        .clk    (clk),
        .reset  (reset),
        .i_cmd  (w_cmd),
        .i_data (r_src),
        .i_amt  (w_amt),
        .o_q    (result)
    );

    assign busy      = (r_state != ST_IDLE);
    assign done      = (r_state == ST_DONE);
    assign err       = done && r_dec.illegal;
    assign shamt_sel = r_dec.sel;
    assign shift_op  = w_cmd;

endmodule
`default_nettype wire
